capture_sequencer: RTL and testbench

// - Sequences one hydrophone capture: keeps a pre-trigger window in the sample FIFO, qualifies a pulse,

---
 rtl/capture_sequencer.sv | 163 ++++++++++++++++
 tb/tb_capture_sequencer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// Capture sequencer: pre-trigger window, pulse qualification, post-trigger fill, SPI drain.
// Optional CAPTURE_TIMESTAMP_EN latches a free-running cycle count at each trigger.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | disarmed, outputs quiet
// PREFILL  | filling FIFO up to the pre-trigger depth
// ARMED    | sliding pre-trigger window, qualifying samples
// POSTFILL | writing post-trigger samples
// LOAD     | pop next word for SPI, or finish when FIFO is empty
// PRESENT  | word on FIFO output, waiting for the SPI transaction
// HOLDOFF  | quiet period before re-arming
module capture_sequencer #(
    parameter int          PRETRIG_SAMPLES  = 500,
    parameter int          POSTTRIG_SAMPLES = 500,
    parameter logic [15:0] THRESHOLD        = 16'd32,
    parameter logic [15:0] REJECT_FLOOR     = 16'hF800,
    parameter int          QUAL_COUNT       = 20,
    parameter int          HOLDOFF_CYCLES   = 1000,
    parameter int          CNT_W            = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm_en,
    input  logic             sample_valid,
    input  logic [15:0]      sample_data,
    input  logic [CNT_W-1:0] fifo_count,
    input  logic             fifo_empty,
    input  logic             fifo_full,
    output logic             fifo_wr,
    output logic             fifo_rd,
    output logic             fifo_flush,
    output logic             spi_rdy,
    input  logic             transaction_done,
    output logic             trigger_seen,
    output logic             capture_done,
    output logic             overflow,
    output logic             busy,
    output logic [31:0]      trig_timestamp
);

    localparam int QW = $clog2(QUAL_COUNT + 1);
    localparam int PW = $clog2(POSTTRIG_SAMPLES + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, PREFILL, ARMED, POSTFILL, LOAD, PRESENT, HOLDOFF
    } state_t;

    state_t          state, state_nxt;
    logic [QW-1:0]   qual_cnt;
    logic [PW-1:0]   post_cnt;
    logic [HW-1:0]   holdoff_cnt;

    logic code_ok, pre_full, qual_hit, post_last, hold_tc;

    assign code_ok   = (sample_data >= THRESHOLD) && (sample_data < REJECT_FLOOR);
    assign pre_full  = fifo_count >= CNT_W'(PRETRIG_SAMPLES);
    // Disarm takes priority over a trigger arriving in the same cycle.
    assign qual_hit  = (state == ARMED) && arm_en && sample_valid && code_ok &&
                       (qual_cnt == QW'(QUAL_COUNT - 1));
    assign post_last = post_cnt == PW'(POSTTRIG_SAMPLES);
    assign hold_tc   = holdoff_cnt == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (arm_en) state_nxt = PREFILL;
            PREFILL:  if (!arm_en) state_nxt = IDLE;
                      else if (pre_full) state_nxt = ARMED;
            ARMED:    if (!arm_en) state_nxt = IDLE;
                      else if (qual_hit) state_nxt = POSTFILL;
            POSTFILL: if (post_last) state_nxt = LOAD;
            LOAD:     state_nxt = fifo_empty ? HOLDOFF : PRESENT;
            PRESENT:  if (transaction_done) state_nxt = LOAD;
            HOLDOFF:  if (hold_tc) state_nxt = arm_en ? PREFILL : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fifo_wr = 1'b0;
        fifo_rd = 1'b0;
        case (state)
            PREFILL:  fifo_wr = sample_valid;
            ARMED: begin
                fifo_wr = sample_valid;
                fifo_rd = sample_valid && pre_full && !qual_hit;
            end
            POSTFILL: fifo_wr = sample_valid && !fifo_full && !post_last;
            LOAD:     fifo_rd = !fifo_empty;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_flush   <= 1'b0;
            trigger_seen <= 1'b0;
            capture_done <= 1'b0;
            spi_rdy      <= 1'b0;
            busy         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            fifo_flush   <= (state_nxt == PREFILL) && (state != PREFILL);
            trigger_seen <= qual_hit;
            capture_done <= (state == LOAD) && fifo_empty;
            spi_rdy      <= state_nxt == PRESENT;
            busy         <= state_nxt != IDLE;
            if ((state == HOLDOFF) && (state_nxt != HOLDOFF))
                overflow <= 1'b0;
            else if ((state == POSTFILL) && sample_valid && fifo_full && !post_last)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qual_cnt    <= '0;
            post_cnt    <= '0;
            holdoff_cnt <= '0;
        end else begin
            if ((state != ARMED) || (state_nxt != ARMED))
                qual_cnt <= '0;
            else if (sample_valid)
                qual_cnt <= !code_ok ? '0 :
                            (qual_cnt == QW'(QUAL_COUNT)) ? qual_cnt : qual_cnt + QW'(1);

            if (qual_hit)
                post_cnt <= PW'(1);
            else if ((state == POSTFILL) && sample_valid && !post_last)
                post_cnt <= post_cnt + PW'(1);

            // Down-counter loaded on entry so HOLDOFF lasts exactly HOLDOFF_CYCLES cycles.
            if ((state == LOAD) && fifo_empty)
                holdoff_cnt <= HW'(HOLDOFF_CYCLES - 1);
            else if ((state == HOLDOFF) && !hold_tc)
                holdoff_cnt <= holdoff_cnt - HW'(1);
        end
    end

`ifdef CAPTURE_TIMESTAMP_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt      <= '0;
            trig_timestamp <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (qual_hit) trig_timestamp <= cycle_cnt;
        end
    end
`else
    assign trig_timestamp = '0;
`endif

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer with a small occupancy-only FIFO model around it.
module tb_capture_sequencer;

    localparam int PRE = 8, POST = 4, QUAL = 3, HOLD = 5, CW = 14, DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm_en = 1'b0;
    logic          sample_valid = 1'b0;
    logic [15:0]   sample_data = '0;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_full;
    logic          fifo_wr, fifo_rd, fifo_flush, spi_rdy;
    logic          transaction_done = 1'b0;
    logic          trigger_seen, capture_done, overflow, busy;
    logic [31:0]   trig_timestamp;
    logic          force_full = 1'b0;

    logic [CW-1:0] model_cnt = '0;
    int wr_total = 0, rd_total = 0, trig_total = 0;
    int n_tests = 0, n_fail = 0;

    capture_sequencer #(
        .PRETRIG_SAMPLES(PRE), .POSTTRIG_SAMPLES(POST), .THRESHOLD(16'd32),
        .REJECT_FLOOR(16'hF800), .QUAL_COUNT(QUAL), .HOLDOFF_CYCLES(HOLD), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .arm_en(arm_en), .sample_valid(sample_valid),
        .sample_data(sample_data), .fifo_count(fifo_count), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_flush(fifo_flush),
        .spi_rdy(spi_rdy), .transaction_done(transaction_done), .trigger_seen(trigger_seen),
        .capture_done(capture_done), .overflow(overflow), .busy(busy),
        .trig_timestamp(trig_timestamp)
    );

    always #5 clk = ~clk;

    assign fifo_count = model_cnt;
    assign fifo_empty = model_cnt == '0;
    assign fifo_full  = force_full || (model_cnt == CW'(DEPTH));

    always @(posedge clk) begin
        if (fifo_flush) model_cnt <= '0;
        else            model_cnt <= model_cnt + {13'b0, fifo_wr} - {13'b0, fifo_rd};
        if (fifo_wr)      wr_total   <= wr_total + 1;
        if (fifo_rd)      rd_total   <= rd_total + 1;
        if (trigger_seen) trig_total <= trig_total + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        sample_valid = 1'b1;
        sample_data  = v;
        tick;
        sample_valid = 1'b0;
        tick;
    endtask

    task automatic readout(input bit hold_first, output int words, output bit done);
        bit held = 1'b0;
        words = 0;
        done  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (capture_done) begin
                done = 1'b1;
                break;
            end
            if (spi_rdy) begin
                if (hold_first && !held) begin
                    held = 1'b1;
                    tick; tick;
                    n_tests++;
                    if (spi_rdy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL spi_rdy_hold: got %b want 1", spi_rdy);
                    end
                end
                words++;
                transaction_done = 1'b1;
                tick;
                transaction_done = 1'b0;
            end else begin
                tick;
            end
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL readout_timeout: capture_done not seen, words=%0d", words);
        end
    endtask

    task automatic arm_and_prefill;
        arm_en = 1'b1;
        tick;
        tick;
        repeat (PRE) send(16'd5);
    endtask

    task automatic test_reset;
        repeat (2) tick;
        n_tests++;
        if ({busy, spi_rdy, fifo_flush, trigger_seen, capture_done, overflow, fifo_wr, fifo_rd} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 00000000",
                     {busy, spi_rdy, fifo_flush, trigger_seen, capture_done, overflow, fifo_wr, fifo_rd});
        end
        n_tests++;
        if (trig_timestamp !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_timestamp: got %0d want 0", trig_timestamp);
        end
        rst = 1'b0;
        tick;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_disarmed_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_prefill_window;
        int wr0, rd0, tr0;
        arm_en = 1'b1;
        tick;
        n_tests++;
        if (fifo_flush !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL arm_flush: flush=%b busy=%b want 1 1", fifo_flush, busy);
        end
        tick;
        n_tests++;
        if (fifo_flush !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_one_cycle: got %b want 0", fifo_flush);
        end
        wr0 = wr_total; rd0 = rd_total; tr0 = trig_total;
        repeat (20) send(16'd5);
        n_tests++;
        if (model_cnt !== CW'(PRE)) begin
            n_fail++;
            $display("FAIL window_count: got %0d want %0d", model_cnt, PRE);
        end
        n_tests++;
        if (wr_total - wr0 != 20 || rd_total - rd0 != 12) begin
            n_fail++;
            $display("FAIL window_strobes: wr=%0d rd=%0d want 20 12", wr_total - wr0, rd_total - rd0);
        end
        n_tests++;
        if (trig_total != tr0) begin
            n_fail++;
            $display("FAIL window_no_trigger: got %0d triggers want 0", trig_total - tr0);
        end
    endtask

    task automatic test_reject;
        int tr0 = trig_total;
        repeat (10) send(16'hFFF0);
        n_tests++;
        if (dut.qual_cnt !== 0 || trig_total != tr0) begin
            n_fail++;
            $display("FAIL negative_reject: qual=%0d trig=%0d want 0 0", dut.qual_cnt, trig_total - tr0);
        end
        send(16'hF7FF);
        n_tests++;
        if (dut.qual_cnt !== 1) begin
            n_fail++;
            $display("FAIL below_floor_valid: qual=%0d want 1", dut.qual_cnt);
        end
        send(16'hF800);
        n_tests++;
        if (dut.qual_cnt !== 0) begin
            n_fail++;
            $display("FAIL floor_rejected: qual=%0d want 0", dut.qual_cnt);
        end
        send(16'd32);
        n_tests++;
        if (dut.qual_cnt !== 1) begin
            n_fail++;
            $display("FAIL threshold_valid: qual=%0d want 1", dut.qual_cnt);
        end
        send(16'd31);
        n_tests++;
        if (dut.qual_cnt !== 0 || model_cnt !== CW'(PRE)) begin
            n_fail++;
            $display("FAIL below_threshold: qual=%0d count=%0d want 0 %0d", dut.qual_cnt, model_cnt, PRE);
        end
    endtask

    task automatic test_qualify;
        int tr0 = trig_total;
        send(16'd40);
        send(16'd40);
        send(16'd5);
        n_tests++;
        if (dut.qual_cnt !== 0) begin
            n_fail++;
            $display("FAIL streak_reset: qual=%0d want 0", dut.qual_cnt);
        end
        send(16'd40);
        sample_valid = 1'b1; sample_data = 16'd40;
        #1;
        n_tests++;
        if (fifo_wr !== 1'b1 || fifo_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL armed_drop_oldest: wr=%b rd=%b want 1 1", fifo_wr, fifo_rd);
        end
        tick;
        sample_valid = 1'b0;
        tick;
        n_tests++;
        if (trig_total != tr0) begin
            n_fail++;
            $display("FAIL early_trigger: got %0d triggers want 0", trig_total - tr0);
        end
        sample_valid = 1'b1; sample_data = 16'd40;
        #1;
        n_tests++;
        if (fifo_wr !== 1'b1 || fifo_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL trigger_no_drop: wr=%b rd=%b want 1 0", fifo_wr, fifo_rd);
        end
        tick;
        sample_valid = 1'b0;
        n_tests++;
        if (trigger_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL trigger_pulse: got %b want 1", trigger_seen);
        end
`ifndef CAPTURE_TIMESTAMP_EN
        n_tests++;
        if (trig_timestamp !== 32'd0) begin
            n_fail++;
            $display("FAIL timestamp_tied: got %0d want 0", trig_timestamp);
        end
`else
        n_tests++;
        if (trig_timestamp == 32'd0) begin
            n_fail++;
            $display("FAIL timestamp_latch: got %0d want nonzero", trig_timestamp);
        end
`endif
        tick;
        n_tests++;
        if (trigger_seen !== 1'b0 || model_cnt !== CW'(PRE + 1)) begin
            n_fail++;
            $display("FAIL trigger_after: pulse=%b count=%0d want 0 %0d", trigger_seen, model_cnt, PRE + 1);
        end
    endtask

    task automatic test_readout_rearm;
        int words, rd0;
        bit done;
        repeat (POST - 1) send(16'd100);
        n_tests++;
        if (model_cnt !== CW'(PRE + POST)) begin
            n_fail++;
            $display("FAIL postfill_count: got %0d want %0d", model_cnt, PRE + POST);
        end
        rd0 = rd_total;
        readout(1'b1, words, done);
        n_tests++;
        if (words != PRE + POST || rd_total - rd0 != PRE + POST) begin
            n_fail++;
            $display("FAIL readout_words: words=%0d rd=%0d want %0d", words, rd_total - rd0, PRE + POST);
        end
        n_tests++;
        if (busy !== 1'b1 || spi_rdy !== 1'b0 || model_cnt !== '0) begin
            n_fail++;
            $display("FAIL capture_done_state: busy=%b spi_rdy=%b count=%0d want 1 0 0", busy, spi_rdy, model_cnt);
        end
        repeat (HOLD - 1) tick;
        n_tests++;
        if (busy !== 1'b1 || fifo_flush !== 1'b0) begin
            n_fail++;
            $display("FAIL holdoff_length: busy=%b flush=%b want 1 0", busy, fifo_flush);
        end
        tick;
        n_tests++;
        if (fifo_flush !== 1'b1) begin
            n_fail++;
            $display("FAIL rearm_flush: got %b want 1", fifo_flush);
        end
    endtask

    task automatic test_overflow;
        int words, tr0;
        bit done;
        tick;
        repeat (PRE) send(16'd5);
        tr0 = trig_total;
        repeat (QUAL) send(16'd40);
        n_tests++;
        if (trig_total - tr0 != 1) begin
            n_fail++;
            $display("FAIL rearm_trigger: got %0d triggers want 1", trig_total - tr0);
        end
        send(16'd100);
        force_full = 1'b1;
        sample_valid = 1'b1; sample_data = 16'd100;
        #1;
        n_tests++;
        if (fifo_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL full_no_write: got %b want 0", fifo_wr);
        end
        tick;
        sample_valid = 1'b0;
        force_full = 1'b0;
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: got %b want 1", overflow);
        end
        tick;
        send(16'd100);
        arm_en = 1'b0;
        readout(1'b0, words, done);
        n_tests++;
        if (words != PRE + POST - 1) begin
            n_fail++;
            $display("FAIL overflow_words: got %0d want %0d", words, PRE + POST - 1);
        end
        repeat (HOLD - 1) tick;
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: got %b want 1", overflow);
        end
        tick;
        n_tests++;
        if (busy !== 1'b0 || overflow !== 1'b0 || fifo_flush !== 1'b0) begin
            n_fail++;
            $display("FAIL holdoff_to_idle: busy=%b ovf=%b flush=%b want 0 0 0", busy, overflow, fifo_flush);
        end
    endtask

    task automatic test_disarm;
        arm_and_prefill();
        send(16'd5);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL armed_busy: got %b want 1", busy);
        end
        arm_en = 1'b0;
        tick;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL disarm_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_in_present;
        arm_and_prefill();
        repeat (QUAL) send(16'd40);
        repeat (POST - 1) send(16'd100);
        tick;
        n_tests++;
        if (spi_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL present_reached: spi_rdy=%b want 1", spi_rdy);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (spi_rdy !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: spi_rdy=%b busy=%b want 0 0", spi_rdy, busy);
        end
        arm_en = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        n_tests++;
        if (busy !== 1'b0 || fifo_flush !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%b flush=%b want 0 0", busy, fifo_flush);
        end
    endtask

    initial begin
        test_reset();
        test_prefill_window();
        test_reject();
        test_qualify();
        test_readout_rearm();
        test_overflow();
        test_disarm();
        test_reset_in_present();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
